// File: rtl/tomasulo_reg_unit_pkg.sv
// Shared types and constants for the Tomasulo register unit.
// Contents: default widths, tag_t, reg_addr_t, the cdb_t broadcast payload
// and NO_TAG, the reserved tag value that means "no producer".
package tomasulo_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned NREG   = 32;
  localparam int unsigned REG_AW = $clog2(NREG);

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef struct packed {
    logic            valid;
    tag_t            tag;
    logic [XLEN-1:0] data;
  } cdb_t;

  localparam tag_t NO_TAG = '0;

endpackage

// File: rtl/tomasulo_reg_unit_if.sv
// Bus bundle between issue logic and the register unit.
// master: issue side. It drives the read addresses, the rename request,
//         the CDB broadcasts and flush, and receives the read results.
// slave : register unit. It receives the requests and drives rd_data,
//         rd_busy and rd_tag, which are combinational.
interface tomasulo_reg_unit_if #(
  parameter int unsigned XLEN  = tomasulo_pkg::XLEN,
  parameter int unsigned TAG_W = tomasulo_pkg::TAG_W,
  parameter int unsigned NREG  = 32,
  parameter int unsigned NRD   = 4,
  parameter int unsigned NCDB  = 1
);
  localparam int unsigned AW = $clog2(NREG);

  logic [NRD-1:0][AW-1:0]     rd_addr;
  logic [NRD-1:0][XLEN-1:0]   rd_data;
  logic [NRD-1:0]             rd_busy;
  logic [NRD-1:0][TAG_W-1:0]  rd_tag;

  logic                       iss_valid;
  logic [AW-1:0]              iss_rd;
  logic [TAG_W-1:0]           iss_tag;

  logic [NCDB-1:0]            cdb_valid;
  logic [NCDB-1:0][TAG_W-1:0] cdb_tag;
  logic [NCDB-1:0][XLEN-1:0]  cdb_data;

  logic                       flush;

  modport master (
    output rd_addr, iss_valid, iss_rd, iss_tag,
           cdb_valid, cdb_tag, cdb_data, flush,
    input  rd_data, rd_busy, rd_tag
  );

  modport slave (
    input  rd_addr, iss_valid, iss_rd, iss_tag,
           cdb_valid, cdb_tag, cdb_data, flush,
    output rd_data, rd_busy, rd_tag
  );

endinterface

// File: rtl/tomasulo_reg_unit_entry.sv
// reg_status_entry: one architectural register together with its status.
// It holds the data value, the busy bit and the producer tag, and resolves
// rename, CDB write and flush in the same cycle with these priorities:
//   busy/tag: flush > rename > CDB match
//   data    : written on a CDB match unless a rename of this register
//             survives in the same cycle
// Ports: clk, rst (sync, active-high), iss_sel (rename targets this
// register), iss_tag, flush, cdb_valid/cdb_tag/cdb_data, busy/tag/data
// (registered state). When TOMASULO_RF_BYPASS_EN is defined the entry also
// exports a per-CDB-port match vector that the read-port forwarding uses.
module reg_status_entry
  import tomasulo_pkg::*;
#(
  parameter int unsigned XLEN  = tomasulo_pkg::XLEN,
  parameter int unsigned TAG_W = tomasulo_pkg::TAG_W,
  parameter int unsigned NCDB  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       iss_sel,
  input  logic [TAG_W-1:0]           iss_tag,
  input  logic                       flush,
  input  logic [NCDB-1:0]            cdb_valid,
  input  logic [NCDB-1:0][TAG_W-1:0] cdb_tag,
  input  logic [NCDB-1:0][XLEN-1:0]  cdb_data,
`ifdef TOMASULO_RF_BYPASS_EN
  output logic [NCDB-1:0]            match,
`endif
  output logic                       busy,
  output logic [TAG_W-1:0]           tag,
  output logic [XLEN-1:0]            data
);

  logic [NCDB-1:0] match_c;
  logic            hit_c;
  logic [XLEN-1:0] hit_data_c;
  logic            data_we_c;

  // A CDB port hits only while this register is still waiting on that tag.
  always_comb begin
    match_c    = '0;
    hit_data_c = '0;
    for (int k = NCDB - 1; k >= 0; k--) begin
      match_c[k] = busy && cdb_valid[k] && (tag == cdb_tag[k]);
      if (match_c[k]) hit_data_c = cdb_data[k];
    end
    hit_c = |match_c;
    // A surviving rename makes the broadcast stale for this register.
    data_we_c = hit_c && !(iss_sel && !flush);
  end

`ifdef TOMASULO_RF_BYPASS_EN
  assign match = match_c;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      tag  <= TAG_W'(NO_TAG);
      data <= '0;
    end else begin
      if (data_we_c) data <= hit_data_c;
      if (flush) begin
        busy <= 1'b0;
        tag  <= TAG_W'(NO_TAG);
      end else if (iss_sel) begin
        busy <= 1'b1;
        tag  <= iss_tag;
      end else if (hit_c) begin
        busy <= 1'b0;
        tag  <= TAG_W'(NO_TAG);
      end
    end
  end

endmodule

// File: rtl/tomasulo_reg_unit.sv
// tomasulo_reg_unit: architectural register file with an integrated
// Tomasulo register-status table (busy bit and producer tag per register).
// Ports: clk, rst (synchronous, active-high), bus (tomasulo_reg_unit_if.slave):
//   rd_addr/rd_data/rd_busy/rd_tag : NRD combinational read ports
//   iss_valid/iss_rd/iss_tag       : one rename request per cycle
//   cdb_valid/cdb_tag/cdb_data     : NCDB result broadcasts per cycle
//   flush                          : squash all pending producers
// Register 0 reads as zero and is never renamed.
// Optional macro TOMASULO_RF_BYPASS_EN: read ports forward a same-cycle
// CDB result for a busy register whose tag is being broadcast.
module tomasulo_reg_unit
  import tomasulo_pkg::*;
#(
  parameter int unsigned XLEN  = tomasulo_pkg::XLEN,
  parameter int unsigned NREG  = 32,
  parameter int unsigned NRD   = 4,
  parameter int unsigned NCDB  = 1,
  parameter int unsigned TAG_W = tomasulo_pkg::TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  tomasulo_reg_unit_if.slave bus
);

  localparam int unsigned AW = $clog2(NREG);

  logic [XLEN-1:0]  data_v [NREG];
  logic             busy_v [NREG];
  logic [TAG_W-1:0] tag_v  [NREG];
`ifdef TOMASULO_RF_BYPASS_EN
  logic [NCDB-1:0]  match_v [NREG];
`endif

  // Register 0 has no storage and no producer.
  assign data_v[0] = '0;
  assign busy_v[0] = 1'b0;
  assign tag_v[0]  = TAG_W'(NO_TAG);
`ifdef TOMASULO_RF_BYPASS_EN
  assign match_v[0] = '0;
`endif

  for (genvar r = 1; r < NREG; r++) begin : g_entry
    logic iss_sel;
    assign iss_sel = bus.iss_valid && (bus.iss_rd == AW'(r));

    reg_status_entry #(
      .XLEN  (XLEN),
      .TAG_W (TAG_W),
      .NCDB  (NCDB)
    ) u_entry (
      .clk       (clk),
      .rst       (rst),
      .iss_sel   (iss_sel),
      .iss_tag   (bus.iss_tag),
      .flush     (bus.flush),
      .cdb_valid (bus.cdb_valid),
      .cdb_tag   (bus.cdb_tag),
      .cdb_data  (bus.cdb_data),
`ifdef TOMASULO_RF_BYPASS_EN
      .match     (match_v[r]),
`endif
      .busy      (busy_v[r]),
      .tag       (tag_v[r]),
      .data      (data_v[r])
    );
  end

  // Read ports: pre-edge state, optionally overridden by a same-cycle broadcast.
  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      bus.rd_data[p] = data_v[bus.rd_addr[p]];
      bus.rd_busy[p] = busy_v[bus.rd_addr[p]];
      bus.rd_tag[p]  = tag_v[bus.rd_addr[p]];
`ifdef TOMASULO_RF_BYPASS_EN
      for (int k = 0; k < NCDB; k++) begin
        if (match_v[bus.rd_addr[p]][k]) begin
          bus.rd_data[p] = bus.cdb_data[k];
          bus.rd_busy[p] = 1'b0;
          bus.rd_tag[p]  = TAG_W'(NO_TAG);
        end
      end
`endif
    end
  end

  // Illegal-input detection: duplicate live CDB tags, zero rename tag.
  logic cdb_dup_c;
  always_comb begin
    cdb_dup_c = 1'b0;
    for (int i = 0; i < NCDB; i++) begin
      for (int j = i + 1; j < NCDB; j++) begin
        if (bus.cdb_valid[i] && bus.cdb_valid[j] &&
            (bus.cdb_tag[i] == bus.cdb_tag[j]))
          cdb_dup_c = 1'b1;
      end
    end
  end

  a_no_dup_cdb_tag : assert property (@(posedge clk) disable iff (rst) !cdb_dup_c);
  a_iss_tag_nonzero : assert property (@(posedge clk) disable iff (rst)
    bus.iss_valid |-> (bus.iss_tag != TAG_W'(NO_TAG)));

endmodule
